alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_pkg.sv | 35 +++
 rtl/alu_mul_seq_if.sv | 35 +++
 rtl/alu_mul_seq_sign_fix.sv | 15 +
 rtl/alu_mul_seq.sv | 133 +++++++++++++
 tb/tb_alu_mul_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_mul_seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_mul_seq_pkg : op/state encodings and ALU select for alu_mul_seq
// Rev 1.0
// ------------------------------------------------------------------
package alu_mul_seq_pkg;

  localparam int ALU_SEL_W = 4;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = 4'h0;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // MUL treats both operands as signed; its low word is sign-agnostic anyway.
  function automatic logic op_a_signed(input logic [1:0] op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_mul_seq_if : request/response handshake plus ALU borrow bus
// Rev 1.0
// ------------------------------------------------------------------
interface alu_mul_seq_if
  import alu_mul_seq_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [XLEN-1:0]      req_a;
  logic [XLEN-1:0]      req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [XLEN-1:0]      resp_data;
  logic                 alu_own;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [XLEN-1:0]      alu_result;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_result,
    output req_ready, resp_valid, resp_data, alu_own, alu_sel, alu_a, alu_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data, alu_own, alu_sel, alu_a, alu_b
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_seq_sign_fix.sv
`default_nettype none
// ------------------------------------------------------------------
// mul_sign_fix : combinational conditional two's-complement negate
// Rev 1.0
// ------------------------------------------------------------------
module mul_sign_fix #(
  parameter int WIDTH = 64
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);
  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
endmodule
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_mul_seq : RV32M multiply sequencer over the shared ALU adder
// Rev 1.0
// ------------------------------------------------------------------
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_mul_seq_if.slave bus
);
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  mul_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mq_q, mq_d;
  logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             a_neg, b_neg, carry;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [2*XLEN-1:0] fix_out;

  assign a_neg = op_a_signed(bus.req_op) & bus.req_a[XLEN-1];
  assign b_neg = op_b_signed(bus.req_op) & bus.req_b[XLEN-1];

  mul_sign_fix #(.WIDTH(XLEN)) u_mag_a (
    .neg_i (a_neg),
    .val_i (bus.req_a),
    .val_o (a_mag)
  );

  mul_sign_fix #(.WIDTH(XLEN)) u_mag_b (
    .neg_i (b_neg),
    .val_i (bus.req_b),
    .val_o (b_mag)
  );

  mul_sign_fix #(.WIDTH(2*XLEN)) u_fix (
    .neg_i (neg_q),
    .val_i ({acc_hi_q, mq_q}),
    .val_o (fix_out)
  );

  // The ALU adder has no carry-out; a wrapped sum is smaller than its addend.
  assign carry = bus.alu_result < acc_hi_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mq_d     = mq_q;
    acc_hi_d = acc_hi_q;
    cnt_d    = cnt_q;

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.alu_own    = 1'b0;
    bus.alu_sel    = '0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          mcand_d  = a_mag;
          mq_d     = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        bus.alu_own = 1'b1;
        bus.alu_sel = ALU_SEL_ADD;
        bus.alu_a   = acc_hi_q;
        bus.alu_b   = mq_q[0] ? mcand_q : '0;
        acc_hi_d    = {carry, bus.alu_result[XLEN-1:1]};
        mq_d        = {bus.alu_result[0], mq_q[XLEN-1:1]};
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        {acc_hi_d, mq_d} = fix_out;
        state_d          = ST_DONE;
      end
      ST_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = (op_q == MUL_OP_MUL) ? mq_q : acc_hi_q;
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mq_q     <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mq_q     <= mq_d;
      acc_hi_q <= acc_hi_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_mul_seq : directed vectors and handshake/reset sequences
// Rev 1.0
// ------------------------------------------------------------------
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.XLEN(32)) bus ();

  alu_mul_seq #(.XLEN(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in for the shared ALU: only the ADD path matters here.
  assign bus.alu_result = (bus.alu_sel == ALU_SEL_ADD) ? (bus.alu_a + bus.alu_b) : 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts at a sample point in IDLE; returns at the sample point after the response is taken.
  task automatic do_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit junk,
                        output logic [31:0] data, output int lat, output int owns, output int viol);
    int k;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = junk;
    bus.req_op    = ~op;
    bus.req_a     = ~a;
    bus.req_b     = a ^ b ^ 32'h5a5a_5a5a;
    lat  = -1;
    owns = 0;
    viol = 0;
    data = 'x;
    k    = 1;
    while (lat < 0 && k < 100) begin
      if (bus.alu_own) begin
        owns++;
        if (bus.alu_sel !== ALU_SEL_ADD) viol++;
      end else if (bus.alu_sel !== 4'h0 || bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
        viol++;
      end
      if (bus.req_ready !== 1'b0) viol++;
      if (bus.resp_valid === 1'b1) begin
        lat = k;
      end else begin
        step();
        k++;
      end
    end
    if (lat >= 0) begin
      data = bus.resp_data;
      for (int h = 0; h < hold; h++) begin
        step();
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== data) viol++;
        if (bus.req_ready !== 1'b0 || bus.alu_own !== 1'b0) viol++;
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] data;
    int lat, owns, viol, stray;

    vecs[0]  = '{MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2]  = '{MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3]  = '{MUL_OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[4]  = '{MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{MUL_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[7]  = '{MUL_OP_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002};
    vecs[8]  = '{MUL_OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[9]  = '{MUL_OP_MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[10] = '{MUL_OP_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
    vecs[11] = '{MUL_OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[12] = '{MUL_OP_MULH,   32'h4000_0000, 32'h4000_0000, 32'h1000_0000};
    vecs[13] = '{MUL_OP_MULH,   32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = 32'h0;
    bus.req_b      = 32'h0;
    bus.resp_ready = 1'b0;
    repeat (3) step();

    chk("reset req_ready",  bus.req_ready,  1'b1);
    chk("reset resp_valid", bus.resp_valid, 1'b0);
    chk("reset resp_data",  bus.resp_data,  32'h0);
    chk("reset alu_own",    bus.alu_own,    1'b0);
    chk("reset alu_sel",    bus.alu_sel,    4'h0);
    chk("reset alu_a|b",    {bus.alu_a, bus.alu_b}, 64'h0);

    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    step();
    chk("idle resp_ready no effect valid", bus.resp_valid, 1'b0);
    chk("idle resp_ready no effect ready", bus.req_ready,  1'b1);
    bus.resp_ready = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      do_txn(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, data, lat, owns, viol);
      chk($sformatf("vec%0d data", i),      data, vecs[i].exp);
      chk($sformatf("vec%0d latency", i),   lat,  34);
      chk($sformatf("vec%0d alu_own", i),   owns, 32);
      chk($sformatf("vec%0d protocol", i),  viol, 0);
      chk($sformatf("vec%0d back idle", i), bus.req_ready, 1'b1);
    end

    // Back-pressure with a competing request held high.
    do_txn(MUL_OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5, 1'b1, data, lat, owns, viol);
    chk("hold data",      data, 32'hFFFF_FFEB);
    chk("hold latency",   lat,  34);
    chk("hold alu_own",   owns, 32);
    chk("hold protocol",  viol, 0);
    chk("hold junk not accepted", bus.alu_own, 1'b0);
    chk("hold back idle", bus.req_ready, 1'b1);

    // Reset while cnt == 10.
    bus.req_valid = 1'b1;
    bus.req_op    = MUL_OP_MUL;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd9;
    step();
    bus.req_valid = 1'b0;
    repeat (10) step();
    chk("midcalc alu_own before rst", bus.alu_own, 1'b1);
    rst_n = 1'b0;
    step();
    chk("midcalc rst alu_own",    bus.alu_own,    1'b0);
    chk("midcalc rst resp_valid", bus.resp_valid, 1'b0);
    chk("midcalc rst req_ready",  bus.req_ready,  1'b1);
    chk("midcalc rst alu_a",      bus.alu_a,      32'h0);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.resp_valid !== 1'b0 || bus.alu_own !== 1'b0) stray++;
      step();
    end
    chk("midcalc result discarded", stray, 0);
    do_txn(MUL_OP_MUL, 32'd3, 32'd5, 0, 1'b0, data, lat, owns, viol);
    chk("post-reset 3x5 data",     data, 32'd15);
    chk("post-reset 3x5 latency",  lat,  34);
    chk("post-reset 3x5 protocol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
